// File: rtl/gpio_pwm.sv
// gpio_pwm: bus-mapped 8-bit PWM / static GPIO driver; define GPIO_PWM_READBACK_EN for register readback
module gpio_pwm #(
  parameter int CHANNELS = 8,
  parameter int PRESCALE = 47
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bus_valid,
  input  logic                bus_we,
  input  logic [3:0]          bus_addr,
  input  logic [31:0]         bus_wdata,
  output logic                bus_ready,
  output logic [31:0]         bus_rdata,
  output logic [CHANNELS-1:0] gpio
);
  localparam int PW = PRESCALE > 0 ? $clog2(PRESCALE + 1) : 1;
  typedef enum logic {IDLE, ACK} state_t;
  state_t state;
  logic [CHANNELS-1:0] mode, level, pwm;
  logic [7:0] duty [CHANNELS];
  logic [7:0] duty_nxt [CHANNELS];
  logic [7:0] active [CHANNELS];
  logic [PW-1:0] presc;
  logic [7:0] phase;
  logic req, wr, tick, wrap;
  assign req = state == IDLE && bus_valid;
  assign wr = req && bus_we;
  assign tick = presc == PW'(PRESCALE);
  assign wrap = tick && phase == 8'hff;
  // duty_nxt folds in a same-edge write so a write on the wrap edge is used at once
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_nxt[i] = wr && bus_addr == 4'(i + 2) ? bus_wdata[7:0] : duty[i];
      pwm[i] = phase < active[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus_ready <= 1'b0;
      mode <= '0;
      level <= '0;
      for (int i = 0; i < CHANNELS; i++) duty[i] <= '0;
    end else begin
      state <= req ? ACK : IDLE;
      bus_ready <= req;
      if (wr && bus_addr == 4'd0) mode <= bus_wdata[CHANNELS-1:0];
      if (wr && bus_addr == 4'd1) level <= bus_wdata[CHANNELS-1:0];
      for (int i = 0; i < CHANNELS; i++) duty[i] <= duty_nxt[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      phase <= '0;
      gpio <= '0;
      for (int i = 0; i < CHANNELS; i++) active[i] <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) phase <= phase + 8'd1;
      if (wrap) for (int i = 0; i < CHANNELS; i++) active[i] <= duty_nxt[i];
      gpio <= (mode & pwm) | (~mode & level);
    end
  end
`ifdef GPIO_PWM_READBACK_EN
  logic [31:0] rd;
  always_comb begin
    rd = '0;
    if (bus_addr == 4'd0) rd[CHANNELS-1:0] = mode;
    if (bus_addr == 4'd1) rd[CHANNELS-1:0] = level;
    if (bus_addr == 4'd15) rd[7:0] = phase;
    for (int i = 0; i < CHANNELS; i++) if (bus_addr == 4'(i + 2)) rd[7:0] = duty[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_rdata <= '0;
    else bus_rdata <= req && !bus_we ? rd : '0;
  end
`else
  assign bus_rdata = '0;
`endif
endmodule
